uart_rx: RTL and testbench
==========================

// Module: uart_rx
// PURPOSE
//  UART receiver for the DE0 Nano: the receive-side counterpart of the UART transmitter.
//  Deserialises 8N1 frames on UART_RX and presents each byte through a valid/ack holding register.
//  Uses the same CLOCK_50 / reset (~KEY[0]) domain as the transmitter.
//  Output bytes can drive the LEDs or be looped back to the transmitter.
// PARAMETERS
//  CLKS_PER_BIT  434  CLOCK_50 cycles per bit (50 MHz / 115200 baud)
//  HALF_BIT      217  cycles from synced start edge to start-bit mid-sample (CLKS_PER_BIT/2)
// PORTS
//  CLOCK_50     in   1  system clock, 50 MHz
//  reset        in   1  asynchronous, active-high reset
//  UART_RX      in   1  serial input; idles high; asynchronous to CLOCK_50
//  rx_data      out  8  last good received byte
//  rx_valid     out  1  high while rx_data holds an unconsumed byte
//  rx_ack       in   1  consumer strobe; clears rx_valid and rx_overrun
//  rx_overrun   out  1  sticky: a byte was dropped because rx_valid was still high
//  frame_err    out  1  one-cycle pulse: stop bit sampled low
//  rx_busy      out  1  high in any state other than IDLE
// BEHAVIOUR
//  Reset (async, active-high): state=IDLE, counters=0, sync flops=1,
//   rx_data=0x00, rx_valid=0, rx_overrun=0, frame_err=0, rx_busy=0.
//  Input path: two-flop synchroniser on UART_RX; the FSM uses only the synced bit (2-cycle delay).
//  Bit counter: 0..CLKS_PER_BIT-1, cleared on each state entry and each bit sample.
//  FSM:
//   IDLE:  synced line=0 -> START, counter=0.
//   START: at count HALF_BIT-1, sample the line.
//          0 -> DATA, bit_idx=0. 1 -> IDLE (glitch; no outputs change).
//   DATA:  every CLKS_PER_BIT cycles, sample into shift reg, LSB first
//          (shift right, new bit into [7]). After bit_idx 7 -> STOP.
//   STOP:  after CLKS_PER_BIT, sample the line.
//          1 -> deliver the byte (below), then IDLE.
//          0 -> frame_err=1 for one cycle, byte discarded, -> BREAK.
//   BREAK: wait for synced line=1, then -> IDLE. No start detection while in BREAK.
//  Delivery, on the good-stop cycle:
//   - rx_valid=0, or rx_ack=1 in the same cycle: rx_data<=shift reg, rx_valid<=1.
//   - rx_valid=1 and rx_ack=0: new byte dropped, rx_data unchanged, rx_overrun<=1.
//  rx_ack with no delivery in that cycle: rx_valid<=0, rx_overrun<=0. rx_ack while rx_valid=0 has no effect.
//  Latency: rx_valid rises ~2 + HALF_BIT + 9*CLKS_PER_BIT cycles after the start edge at the pin
//   (9.5 bit times; bench tolerance +/-3 cycles).
//  Sampling is mid-bit, which tolerates roughly +/-4% baud mismatch.
//  A new start is accepted the cycle after return to IDLE; back-to-back frames are supported.
//  Reset mid-frame aborts the frame with no partial delivery.
//   The first full frame after release is received correctly.
//  Counter widths: clog2(CLKS_PER_BIT) bits; bit_idx is 3 bits. No wrap beyond the terminal count.
// TESTING
//  1. Frame 0x30, 115200 baud, idle gaps -> rx_data=0x30, rx_valid=1 at ~9.5 bit times; frame_err=0.
//  2. UART_RX low for 100 cycles, then high -> no rx_valid, no frame_err; FSM returns to IDLE;
//     next frame 0xA5 is received correctly.
//  3. Frame 0x41 with stop bit forced 0, line held low 2000 cycles -> one frame_err pulse, rx_valid=0,
//     FSM stays in BREAK until the line goes high; then 0x42 is received.
//  4. Frames 0x41 then 0x42, no ack -> rx_data=0x41, rx_overrun=1.
//     rx_ack -> rx_valid=0, rx_overrun=0.
//  5. Back-to-back 0x00, 0xFF; rx_ack pulsed on the same cycle as the second delivery
//     -> rx_data=0xFF, rx_valid=1, rx_overrun=0.
//  6. reset asserted mid-DATA of 0x12 -> all outputs at reset values immediately; after release,
//     frame 0x55 -> rx_data=0x55.

Source files
------------

// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver with two-flop input synchroniser and valid/ack output holding register
module uart_rx #(
  parameter int CLKS_PER_BIT = 434,
  parameter int HALF_BIT     = CLKS_PER_BIT / 2
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       UART_RX,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ack,
  output logic       rx_overrun,
  output logic       frame_err,
  output logic       rx_busy
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BRK} state_t;
  state_t        state;
  logic [1:0]    sync;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shift;
  logic          line;
  assign line = sync[1];
  always_ff @(posedge CLOCK_50 or posedge reset)
    if (reset) begin
      state      <= IDLE;
      sync       <= 2'b11;
      cnt        <= '0;
      bit_idx    <= '0;
      shift      <= '0;
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      rx_overrun <= 1'b0;
      frame_err  <= 1'b0;
      rx_busy    <= 1'b0;
    end else begin
      sync      <= {sync[0], UART_RX};
      frame_err <= 1'b0;
      if (rx_ack) begin
        rx_valid   <= 1'b0;
        rx_overrun <= 1'b0;
      end
      case (state)
        IDLE: begin
          cnt <= '0;
          if (!line) begin
            state   <= START;
            rx_busy <= 1'b1;
          end
        end
        START:
          if (cnt == CW'(HALF_BIT - 1)) begin
            cnt     <= '0;
            bit_idx <= '0;
            state   <= line ? IDLE : DATA;
            rx_busy <= !line;
          end else cnt <= cnt + 1'b1;
        DATA:
          if (cnt == CW'(CLKS_PER_BIT - 1)) begin
            cnt     <= '0;
            shift   <= {line, shift[7:1]};
            bit_idx <= bit_idx + 1'b1;
            if (bit_idx == 3'd7) state <= STOP;
          end else cnt <= cnt + 1'b1;
        STOP:
          if (cnt == CW'(CLKS_PER_BIT - 1)) begin
            cnt     <= '0;
            state   <= line ? IDLE : BRK;
            rx_busy <= !line;
            // an ack in the delivery cycle frees the holding register for the new byte
            if (!line) frame_err <= 1'b1;
            else if (!rx_valid || rx_ack) begin
              rx_data  <= shift;
              rx_valid <= 1'b1;
            end else rx_overrun <= 1'b1;
          end else cnt <= cnt + 1'b1;
        BRK:
          if (line) begin
            state   <= IDLE;
            rx_busy <= 1'b0;
          end
        default: begin
          state   <= IDLE;
          rx_busy <= 1'b0;
        end
      endcase
    end
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed scenario tests for uart_rx at 115200 baud on a 50 MHz clock
module tb_uart_rx;
  localparam int CPB = 434;
  localparam int LAT = 2 + 217 + 9 * CPB;
  logic       CLOCK_50 = 1'b0;
  logic       reset = 1'b1;
  logic       UART_RX = 1'b1;
  logic       rx_ack = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid, rx_overrun, frame_err, rx_busy;
  int         checks = 0;
  int         errors = 0;
  int         fe_cnt = 0;
  uart_rx dut (
    .CLOCK_50(CLOCK_50), .reset(reset), .UART_RX(UART_RX), .rx_data(rx_data),
    .rx_valid(rx_valid), .rx_ack(rx_ack), .rx_overrun(rx_overrun),
    .frame_err(frame_err), .rx_busy(rx_busy)
  );
  always #10 CLOCK_50 = ~CLOCK_50;
  always @(negedge CLOCK_50) if (frame_err) fe_cnt++;
  task automatic send_frame(input logic [7:0] b, input logic stop);
    logic [9:0] f;
    f = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      UART_RX = f[i];
      repeat (CPB) @(negedge CLOCK_50);
    end
  endtask
  task automatic do_ack();
    rx_ack = 1'b1;
    @(negedge CLOCK_50);
    rx_ack = 1'b0;
  endtask
  task automatic test_reset();
    repeat (3) @(negedge CLOCK_50);
    checks += 5;
    if (rx_data !== 8'h00) begin errors++; $display("FAIL reset_data got %h want 00", rx_data); end
    if (rx_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", rx_valid); end
    if (rx_overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun got %b want 0", rx_overrun); end
    if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_frame_err got %b want 0", frame_err); end
    if (rx_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", rx_busy); end
    reset = 1'b0;
    repeat (CPB) @(negedge CLOCK_50);
  endtask
  task automatic test_basic();
    int n;
    n = 0;
    fork
      send_frame(8'h30, 1'b1);
      while (rx_valid !== 1'b1 && n < 6000) begin
        @(negedge CLOCK_50);
        n++;
      end
    join
    checks += 4;
    if (n < LAT - 3 || n > LAT + 3) begin errors++; $display("FAIL basic_latency got %0d want %0d+/-3", n, LAT); end
    if (rx_data !== 8'h30) begin errors++; $display("FAIL basic_data got %h want 30", rx_data); end
    if (rx_valid !== 1'b1) begin errors++; $display("FAIL basic_valid got %b want 1", rx_valid); end
    if (fe_cnt !== 0) begin errors++; $display("FAIL basic_frame_err got %0d pulses want 0", fe_cnt); end
    do_ack();
    repeat (CPB) @(negedge CLOCK_50);
  endtask
  task automatic test_glitch();
    int fe0;
    fe0 = fe_cnt;
    UART_RX = 1'b0;
    repeat (100) @(negedge CLOCK_50);
    UART_RX = 1'b1;
    repeat (300) @(negedge CLOCK_50);
    checks += 3;
    if (rx_busy !== 1'b0) begin errors++; $display("FAIL glitch_busy got %b want 0", rx_busy); end
    if (rx_valid !== 1'b0) begin errors++; $display("FAIL glitch_valid got %b want 0", rx_valid); end
    if (fe_cnt !== fe0) begin errors++; $display("FAIL glitch_frame_err got %0d pulses want 0", fe_cnt - fe0); end
    send_frame(8'hA5, 1'b1);
    checks += 2;
    if (rx_data !== 8'hA5) begin errors++; $display("FAIL glitch_next_data got %h want a5", rx_data); end
    if (rx_valid !== 1'b1) begin errors++; $display("FAIL glitch_next_valid got %b want 1", rx_valid); end
    do_ack();
    repeat (CPB) @(negedge CLOCK_50);
  endtask
  task automatic test_break();
    int fe0;
    fe0 = fe_cnt;
    send_frame(8'h41, 1'b0);
    repeat (2000) @(negedge CLOCK_50);
    checks += 3;
    if (fe_cnt - fe0 !== 1) begin errors++; $display("FAIL break_frame_err got %0d pulses want 1", fe_cnt - fe0); end
    if (rx_valid !== 1'b0) begin errors++; $display("FAIL break_valid got %b want 0", rx_valid); end
    if (rx_busy !== 1'b1) begin errors++; $display("FAIL break_hold_busy got %b want 1", rx_busy); end
    UART_RX = 1'b1;
    repeat (5) @(negedge CLOCK_50);
    checks += 1;
    if (rx_busy !== 1'b0) begin errors++; $display("FAIL break_release_busy got %b want 0", rx_busy); end
    send_frame(8'h42, 1'b1);
    checks += 2;
    if (rx_data !== 8'h42) begin errors++; $display("FAIL break_next_data got %h want 42", rx_data); end
    if (rx_valid !== 1'b1) begin errors++; $display("FAIL break_next_valid got %b want 1", rx_valid); end
    do_ack();
    repeat (CPB) @(negedge CLOCK_50);
  endtask
  task automatic test_overrun();
    send_frame(8'h41, 1'b1);
    send_frame(8'h42, 1'b1);
    checks += 3;
    if (rx_data !== 8'h41) begin errors++; $display("FAIL overrun_data got %h want 41", rx_data); end
    if (rx_valid !== 1'b1) begin errors++; $display("FAIL overrun_valid got %b want 1", rx_valid); end
    if (rx_overrun !== 1'b1) begin errors++; $display("FAIL overrun_flag got %b want 1", rx_overrun); end
    do_ack();
    checks += 2;
    if (rx_valid !== 1'b0) begin errors++; $display("FAIL overrun_ack_valid got %b want 0", rx_valid); end
    if (rx_overrun !== 1'b0) begin errors++; $display("FAIL overrun_ack_flag got %b want 0", rx_overrun); end
    repeat (CPB) @(negedge CLOCK_50);
  endtask
  task automatic test_back_to_back();
    fork
      begin
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
      end
      begin
        repeat (10 * CPB + 100) @(negedge CLOCK_50);
        checks += 2;
        if (rx_data !== 8'h00) begin errors++; $display("FAIL b2b_first_data got %h want 00", rx_data); end
        if (rx_valid !== 1'b1) begin errors++; $display("FAIL b2b_first_valid got %b want 1", rx_valid); end
        repeat (LAT - 100) @(negedge CLOCK_50);
        rx_ack = 1'b1;
        @(negedge CLOCK_50);
        rx_ack = 1'b0;
      end
    join
    checks += 3;
    if (rx_data !== 8'hFF) begin errors++; $display("FAIL b2b_data got %h want ff", rx_data); end
    if (rx_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid got %b want 1", rx_valid); end
    if (rx_overrun !== 1'b0) begin errors++; $display("FAIL b2b_overrun got %b want 0", rx_overrun); end
  endtask
  task automatic test_reset_mid_frame();
    logic [7:0] b;
    b = 8'h12;
    UART_RX = 1'b0;
    repeat (CPB) @(negedge CLOCK_50);
    for (int i = 0; i < 4; i++) begin
      UART_RX = b[i];
      repeat (CPB) @(negedge CLOCK_50);
    end
    UART_RX = b[4];
    repeat (200) @(negedge CLOCK_50);
    reset = 1'b1;
    #1;
    checks += 5;
    if (rx_data !== 8'h00) begin errors++; $display("FAIL midrst_data got %h want 00", rx_data); end
    if (rx_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid got %b want 0", rx_valid); end
    if (rx_overrun !== 1'b0) begin errors++; $display("FAIL midrst_overrun got %b want 0", rx_overrun); end
    if (frame_err !== 1'b0) begin errors++; $display("FAIL midrst_frame_err got %b want 0", frame_err); end
    if (rx_busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got %b want 0", rx_busy); end
    repeat (5) @(negedge CLOCK_50);
    UART_RX = 1'b1;
    reset = 1'b0;
    repeat (20) @(negedge CLOCK_50);
    send_frame(8'h55, 1'b1);
    checks += 2;
    if (rx_data !== 8'h55) begin errors++; $display("FAIL midrst_next_data got %h want 55", rx_data); end
    if (rx_valid !== 1'b1) begin errors++; $display("FAIL midrst_next_valid got %b want 1", rx_valid); end
  endtask
  initial begin
    test_reset();
    test_basic();
    test_glitch();
    test_break();
    test_overrun();
    test_back_to_back();
    test_reset_mid_frame();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
